// File: rtl/fir_pkg.sv
// Shared constants for the FIR sequencer: tap count, byte step, status bit positions, FSM codes.
package fir_pkg;
    localparam int TAPS      = 11;
    localparam int ADDR_STEP = 4;

    localparam int BIT_START = 0;
    localparam int BIT_DONE  = 1;
    localparam int BIT_IDLE  = 2;
    localparam int BIT_ERR   = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    function automatic logic [3:0] pack_status(input logic start, input logic done,
                                               input logic idle, input logic err);
        logic [3:0] v;
        v            = '0;
        v[BIT_START] = start;
        v[BIT_DONE]  = done;
        v[BIT_IDLE]  = idle;
        v[BIT_ERR]   = err;
        return v;
    endfunction
endpackage

// File: rtl/fir_addr_gen.sv
// Circular write pointer and (ptr - tap_idx) mod TAPS_N read index, no divider; combinational index.
module fir_addr_gen #(
    parameter int TAPS_N = 11,
    parameter int IW     = $clog2(TAPS_N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [IW-1:0] tap_idx,
    output logic [IW-1:0] ptr,
    output logic [IW-1:0] data_idx
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == IW'(TAPS_N - 1)) ? '0 : ptr + IW'(1);
        end
    end

    // Wrap by adding TAPS_N when the subtraction would go negative; modular overflow cancels out.
    always_comb begin
        data_idx = (ptr >= tap_idx) ? (ptr - tap_idx) : (ptr + IW'(TAPS_N) - tap_idx);
    end
endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencer (CLR/LOAD/CALC/OUT): 14 cycles per sample unstalled; an OUT stall keeps ss_tready low.
// Define FIR_CTRL_TLAST_CHECK_EN to flag ss_tlast versus sample-count mismatches on ap_err.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = TAPS
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   cfg_start,
    input  logic [pDATA_WIDTH-1:0] cfg_len,
    input  logic                   status_rd,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic                   ap_err,
    output logic                   tap_lock,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   mac_clr,
    output logic                   mac_en
);
    localparam int IW = $clog2(Tape_Num + 1);

    logic [2:0]             state_q;
    logic [IW-1:0]          seq_q;
    logic [pDATA_WIDTH-1:0] len_q;
    logic [pDATA_WIDTH-1:0] cnt_q;
    logic [pDATA_WIDTH-1:0] cnt_nxt;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          data_idx;
    logic                   start_acc;
    logic                   in_hs;
    logic                   last;
    logic                   calc_rd;

    assign start_acc = (state_q == S_IDLE) && cfg_start;
    assign in_hs     = (state_q == S_LOAD) && ss_tvalid;
    assign cnt_nxt   = cnt_q + pDATA_WIDTH'(1);
    assign last      = (cnt_nxt == len_q);
    assign calc_rd   = (state_q == S_CALC) && (seq_q < IW'(Tape_Num));

    fir_addr_gen #(.TAPS_N(Tape_Num), .IW(IW)) u_addr_gen (
        .clk      (axis_clk),
        .rst      (axis_rst),
        .clr      (start_acc),
        .adv      ((state_q == S_OUT) && sm_tready),
        .tap_idx  (seq_q),
        .ptr      (ptr),
        .data_idx (data_idx)
    );

    always_comb begin
        ss_tready = (state_q == S_LOAD);
        sm_tvalid = (state_q == S_OUT);
        sm_tlast  = (state_q == S_OUT) && last;
        tap_EN    = calc_rd;
        tap_A     = calc_rd ? pADDR_WIDTH'(ADDR_STEP * int'(seq_q)) : '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        // Read data lags address by one cycle, so products arrive on seq 1..Tape_Num.
        mac_en    = (state_q == S_CALC) && (seq_q != '0);
        mac_clr   = (state_q == S_CALC) && (seq_q == IW'(1));
        case (state_q)
            S_CLR: begin
                data_EN = 1'b1;
                data_WE = 4'hf;
                data_A  = pADDR_WIDTH'(ADDR_STEP * int'(seq_q));
            end
            S_LOAD: begin
                data_EN = ss_tvalid;
                data_WE = ss_tvalid ? 4'hf : 4'h0;
                data_A  = pADDR_WIDTH'(ADDR_STEP * int'(ptr));
            end
            S_CALC: begin
                data_EN = calc_rd;
                data_A  = calc_rd ? pADDR_WIDTH'(ADDR_STEP * int'(data_idx)) : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q  <= S_IDLE;
            seq_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            ap_start <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= 1'b1;
            tap_lock <= 1'b0;
        end else begin
            ap_start <= 1'b0;
            if (status_rd && ap_done) ap_done <= 1'b0;
            case (state_q)
                S_IDLE: if (cfg_start) begin
                    ap_start <= 1'b1;
                    ap_done  <= 1'b0;
                    ap_idle  <= 1'b0;
                    tap_lock <= 1'b1;
                    len_q    <= cfg_len;
                    cnt_q    <= '0;
                    seq_q    <= '0;
                    state_q  <= (cfg_len == '0) ? S_DONE : S_CLR;
                end
                S_CLR: begin
                    seq_q <= seq_q + IW'(1);
                    if (seq_q == IW'(Tape_Num - 1)) begin
                        seq_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: if (ss_tvalid) begin
                    seq_q   <= '0;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    seq_q <= seq_q + IW'(1);
                    if (seq_q == IW'(Tape_Num)) begin
                        seq_q   <= '0;
                        state_q <= S_OUT;
                    end
                end
                S_OUT: if (sm_tready) begin
                    cnt_q   <= cnt_nxt;
                    state_q <= last ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    ap_done  <= 1'b1;
                    ap_idle  <= 1'b1;
                    tap_lock <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FIR_CTRL_TLAST_CHECK_EN
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            ap_err <= 1'b0;
        end else if (start_acc) begin
            ap_err <= 1'b0;
        end else if (in_hs && (ss_tlast != last)) begin
            ap_err <= 1'b1;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = ss_tlast ^ in_hs;
    assign ap_err       = 1'b0;
`endif
endmodule
